tcb_lib_stream_loader: RTL and testbench
========================================

Name: tcb_lib_stream_loader

Overview:
- Manager-side TCB stage that sits directly upstream of a TCB memory subordinate.
- Converts a byte stream (valid/ready, with a last marker) into sequential TCB write transfers, packing bytes into bus words with byte enables.
- Used to preload test memories from a host/bench stream without file I/O, and as a DMA-style fill engine in SoC benches.
- Supports unaligned start addresses and partial final words.

Parameters:
- DAW, 32, TCB address width in bits.
- DBW, 32, TCB data width in bits; BEW = DBW/8 byte lanes; DBW must be a power of two, 8 or larger.
- DLY, 1, TCB read/write response delay; used only for the outstanding-transfer drain count.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- cfg_str  in  1  start pulse; accepted only in IDLE
- cfg_adr  in  DAW  byte start address, sampled on cfg_str
- sts_bsy  out  1  engine busy (not IDLE)
- sts_don  out  1  one-cycle pulse when the final write has retired
- sts_cnt  out  DAW  bytes written since the last start
- str_vld  in  1  stream byte valid
- str_rdy  out  1  stream byte ready
- str_dat  in  8  stream byte
- str_lst  in  1  last byte of the stream
- tcb_vld  out  1  TCB request valid
- tcb_rdy  in  1  TCB request ready
- tcb_wen  out  1  write enable; constant 1 while tcb_vld
- tcb_adr  out  DAW  word-aligned address (low log2(BEW) bits zero)
- tcb_ben  out  BEW  byte enables
- tcb_wdt  out  DBW  write data, byte b on lane b

Behaviour:
- Reset (rst low, asynchronous) forces: state IDLE; str_rdy=0, tcb_vld=0, tcb_ben=0, tcb_wdt=0, tcb_adr=0, sts_bsy=0, sts_don=0, sts_cnt=0.
- A TCB transfer occurs on any clk edge with tcb_vld & tcb_rdy. A stream beat occurs on any clk edge with str_vld & str_rdy.
- State IDLE:
  - cfg_str=1 latches ptr=cfg_adr, clears sts_cnt, ben and the word buffer, and moves to FILL.
  - cfg_str is ignored in every other state.
- State FILL:
  - str_rdy=1 and tcb_vld=0.
  - Each stream beat writes byte to lane L=ptr%BEW, sets ben[L], increments ptr and sts_cnt.
  - If the beat fills lane BEW-1 or carries str_lst=1, go to SEND on the next cycle.
  - tcb_adr equals ptr with the low bits cleared, captured from the pre-increment ptr.
- State SEND:
  - tcb_vld=1 and str_rdy=0.
  - adr, ben and wdt are held stable until tcb_rdy.
  - On transfer: clear ben and buffer; go to FILL if the word was not last, else DRAIN.
  - Lanes whose ben=0 carry wdt=0.
- State DRAIN:
  - Wait DLY cycles (counter) for the subordinate to retire the last write.
  - Then pulse sts_don for 1 cycle and go to IDLE.
  - With DLY=0, go to IDLE on the next cycle and pulse sts_don.
- Throughput: each word costs at least one extra SEND cycle. Full words need BEW+1 cycles with tcb_rdy=1.
- Unaligned start: the first word has ben set only from lane cfg_adr%BEW upward.
- ptr wraps modulo 2**DAW. sts_cnt saturates at all-ones.
- str_lst on the very first beat produces a single one-byte write.
- A stream beat arriving in IDLE, SEND or DRAIN is not accepted (str_rdy=0). There is no loss of data.
- An asynchronous reset mid-SEND drops tcb_vld immediately; the in-flight word is discarded.
- tcb_rdy may toggle arbitrarily; request fields must not change while tcb_vld=1 and tcb_rdy=0.

Test Plan:
- Aligned fill: DBW=32, cfg_adr=0x100, stream 0x11..0x18 with lst on 0x18 -> writes {adr 0x100, ben 1111, wdt 0x14131211} then {adr 0x104, ben 1111, wdt 0x18171615}; sts_cnt=8; sts_don one pulse DLY cycles after the 2nd transfer.
- Unaligned/partial: cfg_adr=0x203, bytes 0xAA,0xBB,0xCC(lst) -> {0x200, ben 1000, wdt 0xAA000000}, then {0x204, ben 0011, wdt 0x0000CCBB}.
- Backpressure: tcb_rdy held 0 for 5 cycles in SEND -> tcb_vld, adr, ben, wdt stable for all 5 cycles; str_rdy=0; no stream byte consumed.
- Single byte: cfg_adr=0x7, byte 0x5A with lst -> one write {0x4, ben 1000, wdt 0x5A000000}; sts_cnt=1.
- Reset mid-operation: assert rst low during SEND -> tcb_vld=0 in the same cycle (asynchronous); after release, state is IDLE, sts_cnt=0, and a new cfg_str runs cleanly.
- Wrap/ignore: DAW=8, cfg_adr=0xFE, 4 bytes -> writes at 0xFC (ben 1100) then 0x00 (ben 0011); cfg_str pulsed mid-run is ignored.

Source files
------------

// File: rtl/tcb_lib_stream_loader_if.sv
// Stream-in / TCB-out bundle for the stream loader; master is the loader side.
interface tcb_lib_stream_loader_if #(
  parameter int unsigned DAW = 32,
  parameter int unsigned DBW = 32
) ();
  localparam int unsigned BEW = DBW / 8;

  // byte stream
  logic           str_vld;
  logic           str_rdy;
  logic [7:0]     str_dat;
  logic           str_lst;
  // TCB write request
  logic           tcb_vld;
  logic           tcb_rdy;
  logic           tcb_wen;
  logic [DAW-1:0] tcb_adr;
  logic [BEW-1:0] tcb_ben;
  logic [DBW-1:0] tcb_wdt;

  modport master (
    input  str_vld, str_dat, str_lst, tcb_rdy,
    output str_rdy, tcb_vld, tcb_wen, tcb_adr, tcb_ben, tcb_wdt
  );

  modport slave (
    output str_vld, str_dat, str_lst, tcb_rdy,
    input  str_rdy, tcb_vld, tcb_wen, tcb_adr, tcb_ben, tcb_wdt
  );
endinterface

// File: rtl/tcb_lib_stream_loader.sv
// Packs a byte stream into sequential TCB word writes with byte enables.
module tcb_lib_stream_loader #(
  parameter int unsigned DAW = 32,
  parameter int unsigned DBW = 32,
  parameter int unsigned DLY = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_str,
  input  logic [DAW-1:0] cfg_adr,
  output logic           sts_bsy,
  output logic           sts_don,
  output logic [DAW-1:0] sts_cnt,
  tcb_lib_stream_loader_if.master bus
);
  localparam int unsigned BEW = DBW / 8;
  localparam int unsigned LW  = (BEW > 1) ? $clog2(BEW) : 1;
  localparam int unsigned DCW = (DLY > 0) ? $clog2(DLY + 1) : 1;

  typedef enum logic [1:0] {IDLE, FILL, SEND, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [DAW-1:0] ptr;
  logic [DAW-1:0] adr_q;
  logic [BEW-1:0] ben_q;
  logic [DBW-1:0] wdt_q;
  logic           lst_q;
  logic [DCW-1:0] dly_cnt;
  logic           rdy_q, vld_q, bsy_q, don_q;
  logic           rdy_nxt, vld_nxt, bsy_nxt, don_nxt;
  logic [LW-1:0]  lane;
  logic           beat, xfer, dly_done;

  assign lane     = LW'(ptr % DAW'(BEW));
  assign beat     = bus.str_vld & rdy_q;
  assign xfer     = vld_q & bus.tcb_rdy;
  assign dly_done = (dly_cnt == DCW'(DLY));

  assign bus.str_rdy = rdy_q;
  assign bus.tcb_vld = vld_q;
  assign bus.tcb_wen = vld_q;
  assign bus.tcb_adr = adr_q;
  assign bus.tcb_ben = ben_q;
  assign bus.tcb_wdt = wdt_q;
  assign sts_bsy     = bsy_q;
  assign sts_don     = don_q;

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cfg_str) state_nxt = FILL;
      FILL:  if (beat && ((lane == LW'(BEW - 1)) || bus.str_lst)) state_nxt = SEND;
      SEND:  if (xfer) state_nxt = lst_q ? DRAIN : FILL;
      DRAIN: if (dly_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // output decode, computed from the upcoming state so the flops track it
  always_comb begin
    rdy_nxt = 1'b0;
    vld_nxt = 1'b0;
    bsy_nxt = 1'b0;
    don_nxt = 1'b0;
    rdy_nxt = (state_nxt == FILL);
    vld_nxt = (state_nxt == SEND);
    bsy_nxt = (state_nxt != IDLE);
    don_nxt = (state == DRAIN) && dly_done;
  end

  // registered handshake and status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      bsy_q <= 1'b0;
      don_q <= 1'b0;
    end else begin
      rdy_q <= rdy_nxt;
      vld_q <= vld_nxt;
      bsy_q <= bsy_nxt;
      don_q <= don_nxt;
    end
  end

  // byte packing, address pointer, byte counter and drain counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= '0;
      adr_q   <= '0;
      ben_q   <= '0;
      wdt_q   <= '0;
      lst_q   <= 1'b0;
      sts_cnt <= '0;
      dly_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_str) begin
            ptr     <= cfg_adr;
            sts_cnt <= '0;
            ben_q   <= '0;
            wdt_q   <= '0;
            lst_q   <= 1'b0;
          end
        end
        FILL: begin
          if (beat) begin
            wdt_q[{lane, 3'b000} +: 8] <= bus.str_dat;
            ben_q[lane]                <= 1'b1;
            adr_q                      <= ptr & ~DAW'(BEW - 1);
            ptr                        <= ptr + DAW'(1);
            lst_q                      <= bus.str_lst;
            if (sts_cnt != '1) sts_cnt <= sts_cnt + DAW'(1);
          end
        end
        SEND: begin
          // unused lanes stay zero because the buffer is cleared per word
          if (xfer) begin
            ben_q <= '0;
            wdt_q <= '0;
          end
        end
        default: ;
      endcase
      if (state == DRAIN && !dly_done) dly_cnt <= dly_cnt + DCW'(1);
      else                             dly_cnt <= '0;
    end
  end
endmodule

// File: tb/tb_tcb_lib_stream_loader.sv
// Scoreboard bench: directed byte streams, expected writes queued, monitors compare.
module tb_tcb_lib_stream_loader;
  localparam int unsigned DLY = 1;

  typedef struct packed {
    logic [31:0] adr;
    logic [3:0]  ben;
    logic [31:0] wdt;
  } exp_t;
  typedef logic [7:0] bytes_t [8];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_str_a = 1'b0, cfg_str_b = 1'b0;
  logic [31:0] cfg_adr_a = '0;
  logic [7:0]  cfg_adr_b = '0;
  logic        bsy_a, don_a, bsy_b, don_b;
  logic [31:0] cnt_a;
  logic [7:0]  cnt_b;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int last_xfer_a = 0, last_xfer_b = 0, dons_a = 0, dons_b = 0;
  exp_t qa[$], qb[$];

  tcb_lib_stream_loader_if #(.DAW(32), .DBW(32)) ifa ();
  tcb_lib_stream_loader_if #(.DAW(8),  .DBW(32)) ifb ();

  tcb_lib_stream_loader #(.DAW(32), .DBW(32), .DLY(DLY)) u_a (
    .clk(clk), .rst(rst), .cfg_str(cfg_str_a), .cfg_adr(cfg_adr_a),
    .sts_bsy(bsy_a), .sts_don(don_a), .sts_cnt(cnt_a), .bus(ifa)
  );
  tcb_lib_stream_loader #(.DAW(8), .DBW(32), .DLY(DLY)) u_b (
    .clk(clk), .rst(rst), .cfg_str(cfg_str_b), .cfg_adr(cfg_adr_b),
    .sts_bsy(bsy_b), .sts_don(don_b), .sts_cnt(cnt_b), .bus(ifb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor A: scoreboard pop, done timing, request stability under backpressure
  logic        pv_a = 1'b0, pr_a = 1'b0;
  logic [67:0] pf_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (ifa.tcb_vld && ifa.tcb_rdy) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL A unexpected write: got adr %0h expected none", ifa.tcb_adr);
        end else begin
          e = qa.pop_front();
          chk("A adr", 64'(ifa.tcb_adr), 64'(e.adr));
          chk("A ben", 64'(ifa.tcb_ben), 64'(e.ben));
          chk("A wdt", 64'(ifa.tcb_wdt), 64'(e.wdt));
          chk("A wen", 64'(ifa.tcb_wen), 64'd1);
        end
        last_xfer_a = cyc;
      end
      if (don_a) begin
        chk("A don delay", 64'(cyc - last_xfer_a), 64'(DLY + 2));
        dons_a++;
      end
      if (ifa.tcb_vld) chk("A str_rdy in SEND", 64'(ifa.str_rdy), 64'd0);
      if (pv_a && !pr_a && ifa.tcb_vld)
        chk("A hold", 64'({ifa.tcb_adr, ifa.tcb_ben, ifa.tcb_wdt}), 64'(pf_a));
    end
    pv_a = ifa.tcb_vld;
    pr_a = ifa.tcb_rdy;
    pf_a = {ifa.tcb_adr, ifa.tcb_ben, ifa.tcb_wdt};
  end

  // monitor B
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      if (ifb.tcb_vld && ifb.tcb_rdy) begin
        if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL B unexpected write: got adr %0h expected none", ifb.tcb_adr);
        end else begin
          e = qb.pop_front();
          chk("B adr", 64'(ifb.tcb_adr), 64'(e.adr));
          chk("B ben", 64'(ifb.tcb_ben), 64'(e.ben));
          chk("B wdt", 64'(ifb.tcb_wdt), 64'(e.wdt));
        end
        last_xfer_b = cyc;
      end
      if (don_b) begin
        chk("B don delay", 64'(cyc - last_xfer_b), 64'(DLY + 2));
        dons_b++;
      end
    end
  end

  task automatic start(input int which, input logic [31:0] a);
    if (which == 0) begin cfg_str_a = 1'b1; cfg_adr_a = a; end
    else            begin cfg_str_b = 1'b1; cfg_adr_b = a[7:0]; end
    @(posedge clk); #1;
    cfg_str_a = 1'b0;
    cfg_str_b = 1'b0;
  endtask

  task automatic send_bytes(input int which, input bytes_t b, input int n);
    for (int i = 0; i < n; i++) begin
      int t;
      logic lst;
      lst = (i == n - 1);
      if (which == 0) begin ifa.str_vld = 1'b1; ifa.str_dat = b[i]; ifa.str_lst = lst; end
      else            begin ifb.str_vld = 1'b1; ifb.str_dat = b[i]; ifb.str_lst = lst; end
      t = 0;
      forever begin
        @(negedge clk);
        if ((which == 0) ? ifa.str_rdy : ifb.str_rdy) begin
          @(posedge clk); #1;
          break;
        end
        t++;
        if (t > 100) begin
          n_chk++; n_fail++;
          $display("FAIL stream timeout: got no str_rdy expected str_rdy within 100 cycles");
          break;
        end
      end
    end
    ifa.str_vld = 1'b0; ifa.str_lst = 1'b0;
    ifb.str_vld = 1'b0; ifb.str_lst = 1'b0;
  endtask

  task automatic wait_idle(input int which);
    int t;
    t = 0;
    forever begin
      @(negedge clk);
      if (!((which == 0) ? bsy_a : bsy_b)) break;
      t++;
      if (t > 200) begin
        n_chk++; n_fail++;
        $display("FAIL idle timeout: got busy expected idle within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bytes_t b;
    ifa.str_vld = 1'b0; ifa.str_dat = '0; ifa.str_lst = 1'b0; ifa.tcb_rdy = 1'b1;
    ifb.str_vld = 1'b0; ifb.str_dat = '0; ifb.str_lst = 1'b0; ifb.tcb_rdy = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst str_rdy", 64'(ifa.str_rdy), 64'd0);
    chk("rst tcb_vld", 64'(ifa.tcb_vld), 64'd0);
    chk("rst tcb_ben", 64'(ifa.tcb_ben), 64'd0);
    chk("rst tcb_wdt", 64'(ifa.tcb_wdt), 64'd0);
    chk("rst tcb_adr", 64'(ifa.tcb_adr), 64'd0);
    chk("rst sts_bsy", 64'(bsy_a), 64'd0);
    chk("rst sts_don", 64'(don_a), 64'd0);
    chk("rst sts_cnt", 64'(cnt_a), 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // aligned fill
    qa.push_back('{32'h100, 4'b1111, 32'h14131211});
    qa.push_back('{32'h104, 4'b1111, 32'h18171615});
    b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18};
    start(0, 32'h100);
    chk("aligned bsy", 64'(bsy_a), 64'd1);
    send_bytes(0, b, 8);
    wait_idle(0);
    chk("aligned cnt", 64'(cnt_a), 64'd8);

    // unaligned start, partial final word
    qa.push_back('{32'h200, 4'b1000, 32'hAA000000});
    qa.push_back('{32'h204, 4'b0011, 32'h0000CCBB});
    b = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start(0, 32'h203);
    send_bytes(0, b, 3);
    wait_idle(0);
    chk("unaligned cnt", 64'(cnt_a), 64'd3);

    // backpressure: request held for 5 cycles, offered byte not taken
    qa.push_back('{32'h300, 4'b1111, 32'h04030201});
    b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    ifa.tcb_rdy = 1'b0;
    start(0, 32'h300);
    send_bytes(0, b, 4);
    ifa.str_vld = 1'b1; ifa.str_dat = 8'hEE;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp tcb_vld", 64'(ifa.tcb_vld), 64'd1);
      chk("bp str_rdy", 64'(ifa.str_rdy), 64'd0);
      chk("bp adr", 64'(ifa.tcb_adr), 64'h300);
      chk("bp ben", 64'(ifa.tcb_ben), 64'hF);
      chk("bp wdt", 64'(ifa.tcb_wdt), 64'h04030201);
    end
    @(posedge clk); #1;
    ifa.tcb_rdy = 1'b1;
    wait_idle(0);
    ifa.str_vld = 1'b0;
    chk("bp cnt", 64'(cnt_a), 64'd4);

    // single byte with last
    qa.push_back('{32'h4, 4'b1000, 32'h5A000000});
    b = '{8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start(0, 32'h7);
    send_bytes(0, b, 1);
    wait_idle(0);
    chk("single cnt", 64'(cnt_a), 64'd1);

    // asynchronous reset during SEND discards the word
    ifa.tcb_rdy = 1'b0;
    b = '{8'h77, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start(0, 32'h400);
    send_bytes(0, b, 1);
    @(negedge clk);
    chk("pre-rst tcb_vld", 64'(ifa.tcb_vld), 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("async rst tcb_vld", 64'(ifa.tcb_vld), 64'd0);
    chk("async rst bsy", 64'(bsy_a), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    ifa.tcb_rdy = 1'b1;
    @(posedge clk); #1;
    chk("post-rst cnt", 64'(cnt_a), 64'd0);
    chk("post-rst str_rdy", 64'(ifa.str_rdy), 64'd0);
    qa.push_back('{32'h500, 4'b0011, 32'h00000201});
    b = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    start(0, 32'h500);
    send_bytes(0, b, 2);
    wait_idle(0);
    chk("post-rst run cnt", 64'(cnt_a), 64'd2);

    // address wrap on 8-bit bus, mid-run start ignored
    qb.push_back('{32'hFC, 4'b1100, 32'hA2A10000});
    qb.push_back('{32'h00, 4'b0011, 32'h0000A4A3});
    b = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h00, 8'h00, 8'h00, 8'h00};
    start(1, 32'hFE);
    fork
      send_bytes(1, b, 4);
      begin
        repeat (3) @(posedge clk);
        #1 cfg_str_b = 1'b1; cfg_adr_b = 8'h40;
        @(posedge clk); #1 cfg_str_b = 1'b0;
      end
    join
    wait_idle(1);
    chk("wrap cnt", 64'(cnt_b), 64'd4);

    repeat (4) @(posedge clk);
    #1;
    chk("A queue empty", 64'(qa.size()), 64'd0);
    chk("B queue empty", 64'(qb.size()), 64'd0);
    chk("A done pulses", 64'(dons_a), 64'd5);
    chk("B done pulses", 64'(dons_b), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
